// File: rtl/megabytebeat_pkg.sv
// Shared definitions for the bytebeat audio path: default widths and sample type.
package megabytebeat_pkg;

  localparam int SAMPLE_W_DEF = 8;
  localparam int NUM_CH_DEF   = 8;

  typedef logic [SAMPLE_W_DEF-1:0] pcm_t;

  // Width of an unsigned sum of n samples of w bits each.
  function automatic int mix_w(input int w, input int n);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/pcm_pwm_bank_channel.sv
// One PCM-to-PWM channel: one-entry sample queue, playing sample, period-latched
// compare value, sticky underrun flag and the PWM comparator.
module pcm_pwm_channel
  import megabytebeat_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                tick,
  input  logic                ramp_zero,
  input  logic [SAMPLE_W-1:0] ramp,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_vld,
  output logic                s_rdy,
  input  logic                underrun_clr,
  output logic                underrun,
  output logic [SAMPLE_W-1:0] cur,
  output logic                pwm
);

  logic [SAMPLE_W-1:0] nxt;
  logic [SAMPLE_W-1:0] cmp;
  logic                nxt_full;
  logic                take;

  // Ready depends only on state, never on s_vld.
  assign s_rdy = en & ~nxt_full;
  assign take  = s_vld & s_rdy;

  // Queue and playing sample: a tick promotes the queued sample; an accept in
  // the same cycle refills the queue (the tick saw it empty).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nxt      <= '0;
      nxt_full <= 1'b0;
      cur      <= '0;
    end else if (!en) begin
      nxt_full <= 1'b0;
      cur      <= '0;
    end else begin
      if (tick && nxt_full) begin
        cur      <= nxt;
        nxt_full <= 1'b0;
      end
      if (take) begin
        nxt      <= s_data;
        nxt_full <= 1'b1;
      end
    end
  end

  // Sticky underrun; a clear wins over a coincident set, disabled channels hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       underrun <= 1'b0;
    else if (underrun_clr)           underrun <= 1'b0;
    else if (en && tick && !nxt_full) underrun <= 1'b1;
  end

  // Compare value changes only at ramp wrap so a period never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp <= '0;
      pwm <= 1'b0;
    end else begin
      if (ramp_zero) cmp <= cur;
      pwm <= en & (ramp < cmp);
    end
  end

endmodule

// File: rtl/pcm_pwm_bank.sv
// N-channel PCM-to-PWM output stage: programmable sample-rate divider, shared
// PWM ramp, per-channel queues/comparators and an optional channel mixer.
// Optional feature: define PCM_PWM_BANK_MIX_EN to build the mixer and mix_pwm;
// otherwise mix_pwm is tied low and no adder is built.
module pcm_pwm_bank
  import megabytebeat_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DIV_W    = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DIV_W-1:0]           div,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic [NUM_CH*SAMPLE_W-1:0] s_data,
  input  logic [NUM_CH-1:0]          s_vld,
  output logic [NUM_CH-1:0]          s_rdy,
  output logic                       sample_tick,
  output logic [NUM_CH-1:0]          underrun,
  input  logic                       underrun_clr,
  output logic [NUM_CH-1:0]          pwm,
  output logic                       mix_pwm
);

  logic [DIV_W-1:0]                 cnt;
  logic [SAMPLE_W-1:0]              ramp;
  logic                             ramp_zero;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  cur;

  assign ramp_zero = (ramp == '0);

  // Sample-period divider; >= lets a lowered div wrap immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      sample_tick <= 1'b0;
    end else if (cnt >= div) begin
      cnt         <= '0;
      sample_tick <= 1'b1;
    end else begin
      cnt         <= cnt + 1'b1;
      sample_tick <= 1'b0;
    end
  end

  // Free-running PWM ramp shared by all channels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ramp <= '0;
    else       ramp <= ramp + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pcm_pwm_channel #(.SAMPLE_W(SAMPLE_W)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .en           (ch_en[i]),
      .tick         (sample_tick),
      .ramp_zero    (ramp_zero),
      .ramp         (ramp),
      .s_data       (s_data[i*SAMPLE_W +: SAMPLE_W]),
      .s_vld        (s_vld[i]),
      .s_rdy        (s_rdy[i]),
      .underrun_clr (underrun_clr),
      .underrun     (underrun[i]),
      .cur          (cur[i]),
      .pwm          (pwm[i])
    );
  end

`ifdef PCM_PWM_BANK_MIX_EN
  localparam int LG    = $clog2(NUM_CH);
  localparam int MIX_W = mix_w(SAMPLE_W, NUM_CH);

  logic [MIX_W-1:0]    sum;
  logic [SAMPLE_W-1:0] mix;
  logic [SAMPLE_W-1:0] mix_cmp;
  logic                tick_d;

  // Sum of playing samples over enabled channels.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_en[i]) sum = sum + MIX_W'(cur[i]);
  end

  // cur settles on the tick edge, so the mix is captured one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_d <= 1'b0;
      mix    <= '0;
    end else begin
      tick_d <= sample_tick;
      if (tick_d) mix <= sum[MIX_W-1:LG];
    end
  end

  // Mix PWM uses the same wrap-latched compare scheme as the channels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix_cmp <= '0;
      mix_pwm <= 1'b0;
    end else begin
      if (ramp_zero) mix_cmp <= mix;
      mix_pwm <= (ramp < mix_cmp);
    end
  end
`else
  logic unused_cur;
  assign unused_cur = ^cur;
  assign mix_pwm    = 1'b0;
`endif

endmodule

// File: tb/tb_pcm_pwm_bank.sv
// Randomized self-checking bench for pcm_pwm_bank. Expected duty cycles are the
// sample values themselves (high cycles per 256-cycle window), the mix is the
// integer mean of the samples, and tick timing is derived from div.
module tb_pcm_pwm_bank;

  localparam int NUM_CH   = 8;
  localparam int SAMPLE_W = 8;
  localparam int DIV_W    = 9;
  localparam int PER      = 1 << SAMPLE_W;
`ifdef PCM_PWM_BANK_MIX_EN
  localparam bit MIX_EN = 1'b1;
`else
  localparam bit MIX_EN = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic [DIV_W-1:0]           div = '0;
  logic [NUM_CH-1:0]          ch_en = '0;
  logic [NUM_CH*SAMPLE_W-1:0] s_data = '0;
  logic [NUM_CH-1:0]          s_vld = '0;
  logic [NUM_CH-1:0]          s_rdy;
  logic                       sample_tick;
  logic [NUM_CH-1:0]          underrun;
  logic                       underrun_clr = 1'b0;
  logic [NUM_CH-1:0]          pwm;
  logic                       mix_pwm;

  int total = 0;
  int bad   = 0;
  int smp [NUM_CH];
  int hi  [NUM_CH];
  int mix_hi;

  pcm_pwm_bank #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .div          (div),
    .ch_en        (ch_en),
    .s_data       (s_data),
    .s_vld        (s_vld),
    .s_rdy        (s_rdy),
    .sample_tick  (sample_tick),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .pwm          (pwm),
    .mix_pwm      (mix_pwm)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; s_vld = '0; underrun_clr = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      step();
      if (sample_tick) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: sample_tick seen=0 expected=1 within 2000 clk", tag);
    end
  endtask

  task automatic load_all(input logic [NUM_CH-1:0] mask);
    for (int i = 0; i < NUM_CH; i++) s_data[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(smp[i]);
    s_vld = mask;
    step();
    s_vld = '0;
  endtask

  task automatic settle();
    repeat (2*PER + 4) step();
  endtask

  task automatic measure();
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    mix_hi = 0;
    repeat (PER) begin
      step();
      for (int i = 0; i < NUM_CH; i++) hi[i] += int'(pwm[i]);
      mix_hi += int'(mix_pwm);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ch_en = NUM_CH'($urandom);
    step();
    total++;
    if (s_rdy !== ch_en) begin
      bad++; $display("FAIL reset_rdy: s_rdy=%b expected=%b", s_rdy, ch_en);
    end
    total++;
    if ({sample_tick, mix_pwm, underrun, pwm} !== '0) begin
      bad++; $display("FAIL reset_outs: tick=%b mix=%b und=%b pwm=%b expected all 0",
                      sample_tick, mix_pwm, underrun, pwm);
    end
  endtask

  // div=3, no samples: tick every 4 clk, first one on the 4th edge after reset.
  task automatic test_divider();
    int miss, ticks;
    logic [NUM_CH-1:0] pwm_or;
    miss = 0; ticks = 0; pwm_or = '0;
    ch_en = '1; div = 3;
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      step();
      if (sample_tick !== ((k % 4) == 0)) miss++;
      if (sample_tick === 1'b1) ticks++;
      pwm_or |= pwm;
    end
    total++;
    if (miss != 0 || ticks != 16) begin
      bad++; $display("FAIL div3_ticks: ticks=%0d misplaced=%0d expected 16 and 0", ticks, miss);
    end
    total++;
    if (underrun !== '1) begin
      bad++; $display("FAIL div3_underrun: underrun=%b expected=%b", underrun, {NUM_CH{1'b1}});
    end
    total++;
    if (pwm_or !== '0) begin
      bad++; $display("FAIL div3_pwm: pwm seen=%b expected=0", pwm_or);
    end
  endtask

  // Random samples (plus 0x80/0x00/0xFF corners); duty must equal the sample.
  task automatic test_duty();
    int exp_mix, sum;
    do_reset();
    ch_en = '1;
    div = DIV_W'($urandom_range(3, 40));
    step();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NUM_CH; i++) smp[i] = int'($urandom_range(0, PER-1));
      if (r == 0) begin smp[0] = 'h80; smp[1] = 0; smp[2] = PER-1; end
      load_all('1);
      total++;
      if (s_rdy !== '0) begin
        bad++; $display("FAIL duty_rdy_drop r%0d: s_rdy=%b expected=0", r, s_rdy);
      end
      wait_tick("duty_tick");
      settle();
      measure();
      for (int i = 0; i < NUM_CH; i++) begin
        total++;
        if (hi[i] !== smp[i]) begin
          bad++; $display("FAIL duty_ch%0d r%0d: high=%0d expected=%0d", i, r, hi[i], smp[i]);
        end
      end
      sum = 0;
      for (int i = 0; i < NUM_CH; i++) sum += smp[i];
      exp_mix = MIX_EN ? sum / NUM_CH : 0;
      total++;
      if (mix_hi !== exp_mix) begin
        bad++; $display("FAIL duty_mix r%0d: high=%0d expected=%0d", r, mix_hi, exp_mix);
      end
    end
  endtask

  // Disabled channel: not ready, silent, underrun flag frozen.
  task automatic test_disable();
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    ch_en[5] = 1'b0;
    step();
    total++;
    if (s_rdy[5] !== 1'b0) begin
      bad++; $display("FAIL dis_rdy: s_rdy[5]=%b expected=0", s_rdy[5]);
    end
    settle();
    measure();
    total++;
    if (hi[5] !== 0) begin
      bad++; $display("FAIL dis_pwm: high=%0d expected=0", hi[5]);
    end
    total++;
    if (underrun[5] !== 1'b0 || underrun[4] !== 1'b1) begin
      bad++; $display("FAIL dis_underrun: und[5]=%b und[4]=%b expected 0 and 1", underrun[5], underrun[4]);
    end
    ch_en = '1;
  endtask

  // Accept in the tick cycle: underrun set, sample promoted at next tick.
  task automatic test_coincide();
    int d;
    d = int'($urandom_range(1, PER-2));
    do_reset();
    ch_en = '1; div = 7;
    wait_tick("co_first");
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    total++;
    if (underrun !== '0) begin
      bad++; $display("FAIL co_clr: underrun=%b expected=0", underrun);
    end
    wait_tick("co_tick");
    s_data[3*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(d);
    s_vld = NUM_CH'(1) << 3;
    step();
    s_vld = '0;
    total++;
    if (underrun[3] !== 1'b1 || s_rdy[3] !== 1'b0) begin
      bad++; $display("FAIL co_underrun: und[3]=%b rdy[3]=%b expected 1 and 0", underrun[3], s_rdy[3]);
    end
    wait_tick("co_promote");
    step();
    total++;
    if (s_rdy[3] !== 1'b1) begin
      bad++; $display("FAIL co_promote_rdy: s_rdy[3]=%b expected=1", s_rdy[3]);
    end
    settle();
    measure();
    total++;
    if (hi[3] !== d) begin
      bad++; $display("FAIL co_duty: high=%0d expected=%0d", hi[3], d);
    end
    wait_tick("co_clr_tick");
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    total++;
    if (underrun !== '0) begin
      bad++; $display("FAIL co_clr_priority: underrun=%b expected=0", underrun);
    end
  endtask

  // div lowered from 300 to 2 at cnt=100: immediate wrap, then period 3.
  task automatic test_div_change();
    int miss;
    miss = 0;
    ch_en = '1; div = 300;
    do_reset();
    repeat (100) step();
    div = 2;
    step();
    total++;
    if (sample_tick !== 1'b1) begin
      bad++; $display("FAIL divchg_first: tick=%b expected=1", sample_tick);
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      if (sample_tick !== ((k % 3) == 0)) miss++;
    end
    total++;
    if (miss != 0) begin
      bad++; $display("FAIL divchg_period: misplaced=%0d expected=0", miss);
    end
  endtask

  // Async reset mid-cycle: outputs clear at once, queued sample dropped.
  task automatic test_reset_mid();
    ch_en = '1; div = 20;
    do_reset();
    for (int i = 0; i < NUM_CH; i++) smp[i] = 'hC0;
    load_all('1);
    wait_tick("rm_tick");
    repeat (300) step();
    smp[0] = 'h11;
    load_all(NUM_CH'(1));
    total++;
    if (s_rdy[0] !== 1'b0) begin
      bad++; $display("FAIL rm_queued: s_rdy[0]=%b expected=0", s_rdy[0]);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({sample_tick, mix_pwm, underrun, pwm} !== '0 || s_rdy !== ch_en) begin
      bad++; $display("FAIL rm_clear: tick=%b mix=%b und=%b pwm=%b rdy=%b expected 0s and rdy=%b",
                      sample_tick, mix_pwm, underrun, pwm, s_rdy, ch_en);
    end
    step();
    reset = 1'b0;
    repeat (5) step();
    total++;
    if (underrun !== '0 || s_rdy !== '1) begin
      bad++; $display("FAIL rm_after: und=%b rdy=%b expected 0 and all 1", underrun, s_rdy);
    end
  endtask

  // Mixer corner: 0xFF + 0x01 over 8 channels -> duty 32/256.
  task automatic test_mix();
    int exp_mix;
    do_reset();
    ch_en = '1; div = 10;
    for (int i = 0; i < NUM_CH; i++) smp[i] = 0;
    smp[0] = 'hFF; smp[1] = 'h01;
    load_all('1);
    wait_tick("mix_tick");
    settle();
    measure();
    exp_mix = MIX_EN ? 32 : 0;
    total++;
    if (mix_hi !== exp_mix) begin
      bad++; $display("FAIL mix_duty: high=%0d expected=%0d", mix_hi, exp_mix);
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_duty();
    test_disable();
    test_coincide();
    test_div_change();
    test_reset_mid();
    test_mix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
